// File: rtl/frame_sync_gen.sv
// Programmable-rate camera frame timing source (vs/href) driven by a fractional phase accumulator.
// Optional build macro FSG_PATTERN_EN adds an 8-bit pixel ramp on pix_data.
module frame_sync_gen #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned VS_CYCLES   = 16,
  parameter int unsigned BP_CYCLES   = 64,
  parameter int unsigned LINES       = 480,
  parameter int unsigned HREF_CYCLES = 640,
  parameter int unsigned HGAP_CYCLES = 144
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] fps,
  input  logic       overrun_clr,
  output logic       vs,
  output logic       href,
  output logic [7:0] frame_cnt,
  output logic       overrun,
  output logic [7:0] drop_cnt,
  output logic [7:0] pix_data
);

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned MAX_VB = (VS_CYCLES > BP_CYCLES) ? VS_CYCLES : BP_CYCLES;
  localparam int unsigned MAX_HL = (HREF_CYCLES > HGAP_CYCLES) ? HREF_CYCLES : HGAP_CYCLES;
  localparam int unsigned MAX_PH = (MAX_VB > MAX_HL) ? MAX_VB : MAX_HL;
  localparam int unsigned CNT_W  = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    BPORCH,
    LINE_ON,
    LINE_GAP
  } state_t;

  logic [ACC_W-1:0]  acc;
  logic [SUM_W-1:0]  sum;
  logic              tick;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [LINE_W-1:0] line, line_d;
  logic              vs_d, href_d;
  logic [7:0]        frame_cnt_d;
  logic              overrun_d;
  logic [7:0]        drop_cnt_d;
  logic              accept_ok;
  logic              accept;

  // Cadence accumulator: one tick per CLK_HZ/fps cycles on average, remainder carried
  always_comb begin
    sum  = {1'b0, acc} + SUM_W'(fps);
    tick = en && (sum >= SUM_W'(CLK_HZ));
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (!en) begin
      acc <= '0;
    end else if (tick) begin
      acc <= ACC_W'(sum - SUM_W'(CLK_HZ));
    end else begin
      acc <= ACC_W'(sum);
    end
  end

  // Frame-shaping next state; a tick is only taken when the frame slot is free
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    line_d      = line;
    frame_cnt_d = frame_cnt;
    overrun_d   = overrun;
    drop_cnt_d  = drop_cnt;
    accept_ok   = 1'b0;
    accept      = 1'b0;

    case (state)
      IDLE: begin
        accept_ok = 1'b1;
      end
      VSYNC: begin
        if (cnt == CNT_W'(VS_CYCLES - 1)) begin
          state_d = BPORCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      BPORCH: begin
        if (cnt == CNT_W'(BP_CYCLES - 1)) begin
          state_d = LINE_ON;
          cnt_d   = '0;
          line_d  = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      LINE_ON: begin
        if (cnt == CNT_W'(HREF_CYCLES - 1)) begin
          state_d = LINE_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      LINE_GAP: begin
        if (cnt == CNT_W'(HGAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (line == LINE_W'(LINES - 1)) begin
            state_d   = IDLE;
            accept_ok = 1'b1;
          end else begin
            state_d = LINE_ON;
            line_d  = line + LINE_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        line_d  = '0;
      end
    endcase

    accept = tick && accept_ok;
    if (accept) begin
      state_d     = VSYNC;
      cnt_d       = '0;
      line_d      = '0;
      frame_cnt_d = frame_cnt + 8'd1;
    end

    // A drop in the same cycle as a clear restarts the count at one
    if (tick && !accept_ok) begin
      overrun_d  = 1'b1;
      drop_cnt_d = overrun_clr ? 8'd1 :
                   (drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1;
    end else if (overrun_clr) begin
      overrun_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end

    vs_d   = (state_d == VSYNC);
    href_d = (state_d == LINE_ON);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      line      <= '0;
      vs        <= 1'b0;
      href      <= 1'b0;
      frame_cnt <= 8'd0;
      overrun   <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      line      <= line_d;
      vs        <= vs_d;
      href      <= href_d;
      frame_cnt <= frame_cnt_d;
      overrun   <= overrun_d;
      drop_cnt  <= drop_cnt_d;
    end
  end

`ifdef FSG_PATTERN_EN
  logic [7:0] pix_d;

  // Ramp restarts with each frame and advances once per href-high cycle
  always_comb begin
    pix_d = pix_data;
    if (accept) begin
      pix_d = 8'd0;
    end else if (href) begin
      pix_d = pix_data + 8'd1;
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      pix_data <= 8'd0;
    end else begin
      pix_data <= pix_d;
    end
  end
`else
  assign pix_data = 8'd0;
`endif

endmodule

// File: doc/frame_sync_gen.md
Name: frame_sync_gen

Overview:
Frame-timing source that emits camera-style vs/href at a programmable frame rate. It is the transmit-side counterpart of the FPS monitor, and drives the capture pipeline and the FPS monitor during bring-up without a sensor attached. A fractional phase accumulator sets the frame cadence, so the long-run average is exactly fps frames per CLK_HZ cycles. A frame-shaping FSM lays out the vsync, back-porch and line timing of each frame.

Parameters:
CLK_HZ, 50_000_000, clk50 frequency; accumulator modulus
VS_CYCLES, 16, vs high width in clocks (>=1)
BP_CYCLES, 64, low cycles between vs fall and first href (>=1)
LINES, 480, href lines per frame (>=1)
HREF_CYCLES, 640, href high cycles per line (>=1)
HGAP_CYCLES, 144, href low cycles after every line, including the last (>=1)

Ports:
clk50  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  cadence enable
fps  in  8  target frames per second; 0 = no frames
overrun_clr  in  1  one-cycle pulse; clears overrun and drop_cnt
vs  out  1  vertical sync, active high
href  out  1  line valid, active high
frame_cnt  out  8  frames started, wraps 255->0
overrun  out  1  sticky: a tick was dropped
drop_cnt  out  8  dropped ticks, saturates at 255
pix_data  out  8  pixel data (see Optional Feature)

Behaviour:
- Interface: one clock, clk50; reset rst_n is asynchronous and active-low.
- Reset values: acc=0, state=IDLE, vs=0, href=0, frame_cnt=0, overrun=0, drop_cnt=0, pix_data=0. Reset mid-frame aborts the frame immediately.
- Accumulator (32-bit):
  - Each cycle with en=1: sum = acc + fps.
  - If sum >= CLK_HZ: acc <= sum - CLK_HZ and tick=1 for that cycle. Otherwise acc <= sum.
  - en=0: acc held at 0 and no ticks. A frame already in progress runs to completion.
  - fps changes take effect on the next cycle; acc is not cleared.
- FSM states: IDLE, VSYNC, BPORCH, LINE_ON, LINE_GAP. vs, href and pix_data are registered.
- Tick accept:
  - A tick is accepted when state=IDLE, or on the final LINE_GAP cycle of the last line (back-to-back frames).
  - On the next edge: state=VSYNC, vs=1, frame_cnt+1.
  - Latency: the wrap cycle is cycle N; vs is high from cycle N+1.
- Frame sequence:
  - VSYNC: VS_CYCLES cycles, vs=1.
  - BPORCH: BP_CYCLES cycles.
  - LINE_ON: HREF_CYCLES cycles, href=1.
  - LINE_GAP: HGAP_CYCLES cycles.
  - Repeat LINE_ON/LINE_GAP LINES times, then IDLE.
  - Frame length F = VS_CYCLES + BP_CYCLES + LINES*(HREF_CYCLES+HGAP_CYCLES).
- Overrun: a tick in any other state is dropped.
  - overrun <= 1 and drop_cnt+1 (saturating). The current frame is not disturbed.
  - overrun_clr coinciding with a drop: the drop wins (overrun=1, drop_cnt=1).
- Invariant: over any window, accepted frames + dropped ticks = ticks generated.
- Counters: internal line counter is ceil(log2(LINES)) bits; cycle counter is sized for the widest phase.

Optional Feature:
Macro FSG_PATTERN_EN.
- Defined: pix_data is an 8-bit ramp. It is reset to 0 on entering VSYNC, increments after each href-high cycle, wraps at 255, and holds while href=0.
- Not defined: pix_data is tied to 0 and no ramp logic is built.

Test Plan:
CLK_HZ=1000, VS=4, BP=3, LINES=4, HREF=8, HGAP=2 (F=47); fps=10, en=1, 1000 cycles -> exactly 10 vs rising edges, 100 cycles apart; each vs high 4 cycles; 4 href pulses of 8 cycles; first href rise 7 cycles after vs rise; frame_cnt=10; overrun=0.
Same config, fps=3, 1000 cycles -> wraps at cycles 334, 667 and 1000 (acc 2, 1, 0); vs rises at 335, 668 and 1001.
Same config, fps=25, 1000 cycles -> overrun=1; frame_cnt+drop_cnt=25; every frame complete (no truncated href); overrun_clr then drops to 0/0 on the next edge.
Reset mid-frame: assert rst_n=0 during LINE_ON -> vs, href, frame_cnt and pix_data read 0 immediately (asynchronous); after release, first vs rises 100 cycles later at fps=10.
en=0 during BPORCH -> frame finishes all 4 lines; no further vs for 500 cycles; en=1 -> next vs rises 101 cycles later.
FSG_PATTERN_EN defined, fps=10 -> pix_data steps 0..31 across the 32 href-high cycles of each frame; it restarts at 0 on every vs, and is constant 0 when the macro is undefined.
